uart_hex_frame_tx: RTL and testbench
====================================

# uart_hex_frame_tx

Serialises one 16-bit temperature measurement into an ASCII frame of four uppercase hex digits followed by CR LF, transmitted as 8N1 UART on a single output pin. Sits directly downstream of the sensor PWM width-capture stage in tt_um_uart_temp_sens. Accepts one sample per frame through a valid/ready handshake. Flags samples offered while a frame is in flight, since those samples are dropped.

## Interface

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.

Ports:
- clk  input  1  system clock, 50 MHz; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_i  input  16  measurement value; only sampled at acceptance.
- sample_valid_i  input  1  upstream has a sample.
- sample_ready_o  output  1  high only in IDLE; sample accepted on an edge where valid and ready are both 1.
- tx_o  output  1  UART line; idles high.
- busy_o  output  1  high from the cycle after acceptance until the frame completes (equals ~sample_ready_o).
- overrun_o  output  1  one-cycle pulse per cycle where sample_valid_i=1 and sample_ready_o=0.

## Operation

- Frame: 6 bytes, in this order:
  - hex(sample[15:12]), hex([11:8]), hex([7:4]), hex([3:0]), then 0x0D, then 0x0A.
  - hex mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
- Byte format: start bit 0, then 8 data bits LSB first, then 1 stop bit. Each bit is held exactly CLKS_PER_BIT cycles.
- Sample is latched in a 16-bit holding register at acceptance. Later changes on sample_i have no effect on the frame in flight.
- FSM states:
  - IDLE: tx_o=1, ready=1. On valid → latch sample, byte_idx=0, go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles → DATA, bit_idx=0.
  - DATA: tx_o=shift[bit_idx]. After bit_idx=7 completes → STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles.
    - If byte_idx<5: byte_idx+1, go to START. No idle gap between bytes.
    - Else: go to IDLE.
- Byte shift register loads the next character at entry to START.
- Counters:
  - baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1.
  - bit_idx: 3 bits.
  - byte_idx: 3 bits; values 6–7 unreachable.
- Overrun: valid while busy never alters the frame and is never queued.
- Reset behaviour:
  - rst=1 on any edge, including mid-frame: next cycle tx_o=1, state=IDLE, sample_ready_o=1, busy_o=0, overrun_o=0.
  - All counters and the holding register clear to 0.
  - A partial byte is abandoned, not completed.
  - rst has priority over acceptance in the same cycle.

## Timing

- All outputs are registered. Reset values: tx_o=1, sample_ready_o=1, busy_o=0, overrun_o=0.
- Acceptance edge T:
  - tx_o falls, sample_ready_o falls and busy_o rises, all visible after edge T (i.e. during cycle T+1).
- Frame length is exactly 60×CLKS_PER_BIT cycles of tx_o activity.
- sample_ready_o returns to 1 after the final stop bit's last cycle, i.e. visible 60×CLKS_PER_BIT cycles after it fell.
- Back-to-back frames:
  - valid held high → accepted on the first edge ready=1.
  - Minimum gap between frames is 1 cycle of tx_o=1 beyond the stop bit.
- overrun_o is asserted the cycle after the offending valid&~ready edge, for one cycle per such edge.

## Test plan

Benches run with CLKS_PER_BIT=4 unless stated. A UART monitor samples tx_o at mid-bit.

- **Reset:** rst=1 for 3 cycles, valid=0 → tx_o=1, sample_ready_o=1, busy_o=0, overrun_o=0 held throughout and after release.
- **Single frame:** sample 0x1A3F, one-cycle valid → monitor decodes 0x31,0x41,0x33,0x46,0x0D,0x0A. tx_o low first on the cycle after acceptance. ready back high 240 cycles after falling. Stop bits all 1.
- **Digit extremes:** 0x0000 then 0xFFFF → "0000\r\n" (0x30×4) then "FFFF\r\n" (0x46×4). sample_i changed mid-frame has no effect on the output.
- **Overrun:** during a frame of 0x1234, assert valid with 0x9999 for 5 cycles → 5 overrun_o pulses. Frame decodes "1234\r\n". 0x9999 is never transmitted.
- **Back-to-back:** valid held high, sample 0xBEEF then 0x0042 → two complete frames. Exactly 1 idle-high cycle between them.
- **Reset mid-frame:** rst pulsed during byte 2 (CLKS_PER_BIT=434) → tx_o=1 the next cycle and stays high. A subsequent sample 0x00C8 yields a clean "00C8\r\n" with no residue.

Source files
------------

// File: rtl/uart_hex_frame_tx_if.sv
// Sample handshake and UART-side status signals of the hex frame transmitter.
interface uart_hex_frame_tx_if;
  logic [15:0] sample_i;
  logic        sample_valid_i;
  logic        sample_ready_o;
  logic        tx_o;
  logic        busy_o;
  logic        overrun_o;

  modport master (
    output sample_i, sample_valid_i,
    input  sample_ready_o, tx_o, busy_o, overrun_o
  );

  modport slave (
    input  sample_i, sample_valid_i,
    output sample_ready_o, tx_o, busy_o, overrun_o
  );
endinterface

// File: rtl/uart_hex_frame_tx.sv
// Sends one 16-bit sample as "HHHH\r\n" in 8N1 UART framing; samples offered
// while a frame is in flight are dropped and flagged on overrun_o.
module uart_hex_frame_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic           clk,
  input logic           rst,
  uart_hex_frame_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [2:0]    byte_idx, byte_n;
  logic [15:0]   hold, hold_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          baud_done;
  logic          tx_q, ready_q, busy_q, overrun_q;

  // Character for frame position idx: four hex digits, then CR, then LF.
  function automatic logic [7:0] frame_char(input logic [15:0] v, input logic [2:0] idx);
    logic [3:0] nib;
    logic [7:0] ch;
    nib = 4'h0;
    case (idx)
      3'd0:    nib = v[15:12];
      3'd1:    nib = v[11:8];
      3'd2:    nib = v[7:4];
      3'd3:    nib = v[3:0];
      default: nib = 4'h0;
    endcase
    if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
    else             ch = 8'h37 + {4'h0, nib};
    if (idx == 3'd4)      ch = 8'h0D;
    else if (idx > 3'd4)  ch = 8'h0A;
    return ch;
  endfunction

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    hold_n  = hold;
    shift_n = shift;
    tx_n    = 1'b1;

    case (state)
      IDLE: begin
        baud_n = '0;
        if (bus.sample_valid_i) begin
          // The holding register is not loaded yet, so the first character comes from the port.
          hold_n  = bus.sample_i;
          byte_n  = 3'd0;
          bit_n   = 3'd0;
          shift_n = frame_char(bus.sample_i, 3'd0);
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (byte_idx < 3'd5) begin
            byte_n  = byte_idx + 3'd1;
            shift_n = frame_char(hold, byte_idx + 3'd1);
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      byte_idx  <= 3'd0;
      hold      <= 16'h0000;
      shift     <= 8'h00;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      hold      <= hold_n;
      shift     <= shift_n;
      tx_q      <= tx_n;
      ready_q   <= (state_n == IDLE);
      busy_q    <= (state_n != IDLE);
      overrun_q <= bus.sample_valid_i & ~ready_q;
    end
  end

  assign bus.tx_o           = tx_q;
  assign bus.sample_ready_o = ready_q;
  assign bus.busy_o         = busy_q;
  assign bus.overrun_o      = overrun_q;

endmodule

// File: tb/tb_uart_hex_frame_tx.sv
// Self-checking bench: a mid-bit UART monitor decodes tx_o and each frame is
// compared with the bytes expected for the sample that was offered.
module tb_uart_hex_frame_tx;

  localparam int FAST = 4;
  localparam int SLOW = 434;

  logic clk;
  logic rst;
  logic rst_slow;

  uart_hex_frame_tx_if bus4 ();
  uart_hex_frame_tx_if bus434 ();

  uart_hex_frame_tx #(.CLKS_PER_BIT(FAST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  uart_hex_frame_tx #(.CLKS_PER_BIT(SLOW)) dut_slow (
    .clk (clk),
    .rst (rst_slow),
    .bus (bus434)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] rx4[$];
  logic [7:0] rx434[$];
  int se4 = 0;
  int se434 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: ASCII uppercase hex of each nibble, MSB first, then CR LF.
  function automatic logic [7:0] exp_byte(input logic [15:0] v, input int i);
    int d;
    if (i == 4) return 8'h0D;
    if (i == 5) return 8'h0A;
    d = (int'(v) >> (4 * (3 - i))) % 16;
    if (d < 10) return 8'(48 + d);
    return 8'(65 + d - 10);
  endfunction

  task automatic monitor(input bit slow);
    int cpb;
    logic [7:0] b;
    logic line;
    cpb = slow ? SLOW : FAST;
    b = 8'h00;
    forever begin
      @(negedge clk);
      line = slow ? bus434.tx_o : bus4.tx_o;
      if (line === 1'b0) begin
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (cpb) @(negedge clk);
          b[i] = slow ? bus434.tx_o : bus4.tx_o;
        end
        repeat (cpb) @(negedge clk);
        line = slow ? bus434.tx_o : bus4.tx_o;
        if (slow) begin
          if (line !== 1'b1) se434++;
          rx434.push_back(b);
        end else begin
          if (line !== 1'b1) se4++;
          rx4.push_back(b);
        end
      end
    end
  endtask

  initial fork
    monitor(1'b0);
    monitor(1'b1);
  join

  task automatic send4(input logic [15:0] v);
    bus4.sample_i       = v;
    bus4.sample_valid_i = 1'b1;
    @(negedge clk);
    bus4.sample_valid_i = 1'b0;
  endtask

  task automatic wait_ready4(output int n);
    n = 0;
    while (bus4.sample_ready_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rst_slow = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus4.tx_o, bus4.sample_ready_o, bus4.busy_o, bus4.overrun_o} !== 4'b1100) begin
        errors++;
        $display("[TB] FAIL reset_hold: got %b want 1100",
                 {bus4.tx_o, bus4.sample_ready_o, bus4.busy_o, bus4.overrun_o});
      end
    end
    rst = 1'b0;
    rst_slow = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus4.tx_o, bus4.sample_ready_o, bus4.busy_o, bus4.overrun_o,
           bus434.tx_o, bus434.sample_ready_o, bus434.busy_o, bus434.overrun_o} !== 8'b1100_1100) begin
        errors++;
        $display("[TB] FAIL reset_release: got %b want 11001100",
                 {bus4.tx_o, bus4.sample_ready_o, bus4.busy_o, bus4.overrun_o,
                  bus434.tx_o, bus434.sample_ready_o, bus434.busy_o, bus434.overrun_o});
      end
    end
  endtask

  task automatic test_single_frame;
    int n;
    logic [15:0] v;
    v = 16'h1A3F;
    rx4.delete();
    se4 = 0;
    send4(v);
    checks++;
    if (bus4.tx_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_start_low: got %b want 0", bus4.tx_o);
    end
    checks++;
    if ({bus4.sample_ready_o, bus4.busy_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL accept_flags: got %b want 01", {bus4.sample_ready_o, bus4.busy_o});
    end
    wait_ready4(n);
    checks++;
    if (n !== 60 * FAST) begin
      errors++;
      $display("[TB] FAIL ready_return: got %0d cycles want %0d", n, 60 * FAST);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx4.size() !== 6) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d bytes want 6", rx4.size());
    end
    for (int i = 0; i < 6 && i < rx4.size(); i++) begin
      checks++;
      if (rx4[i] !== exp_byte(v, i)) begin
        errors++;
        $display("[TB] FAIL single_byte%0d: got %h want %h", i, rx4[i], exp_byte(v, i));
      end
    end
    checks++;
    if (se4 !== 0) begin
      errors++;
      $display("[TB] FAIL single_stop: got %0d bad stop bits want 0", se4);
    end
  endtask

  task automatic test_digit_extremes;
    int n;
    logic [15:0] v;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 16'h0000 : 16'hFFFF;
      rx4.delete();
      se4 = 0;
      send4(v);
      repeat (50) @(negedge clk);
      bus4.sample_i = 16'($urandom);
      wait_ready4(n);
      checks++;
      if (n >= 2000) begin
        errors++;
        $display("[TB] FAIL extreme_timeout: got %0d cycles want <2000", n);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (rx4.size() !== 6 || se4 !== 0) begin
        errors++;
        $display("[TB] FAIL extreme_count: got %0d bytes %0d bad stops want 6 0", rx4.size(), se4);
      end
      for (int i = 0; i < 6 && i < rx4.size(); i++) begin
        checks++;
        if (rx4[i] !== exp_byte(v, i)) begin
          errors++;
          $display("[TB] FAIL extreme_byte%0d: got %h want %h", i, rx4[i], exp_byte(v, i));
        end
      end
    end
  endtask

  task automatic test_overrun;
    int n;
    int pulses;
    logic [15:0] v;
    v = 16'h1234;
    rx4.delete();
    se4 = 0;
    send4(v);
    repeat (20) @(negedge clk);
    bus4.sample_i = 16'h9999;
    bus4.sample_valid_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus4.overrun_o === 1'b1) pulses++;
      if (i == 4) bus4.sample_valid_i = 1'b0;
    end
    checks++;
    if (pulses !== 5) begin
      errors++;
      $display("[TB] FAIL overrun_pulses: got %0d want 5", pulses);
    end
    wait_ready4(n);
    repeat (20) @(negedge clk);
    checks++;
    if (rx4.size() !== 6 || se4 !== 0) begin
      errors++;
      $display("[TB] FAIL overrun_count: got %0d bytes %0d bad stops want 6 0", rx4.size(), se4);
    end
    for (int i = 0; i < 6 && i < rx4.size(); i++) begin
      checks++;
      if (rx4[i] !== exp_byte(v, i)) begin
        errors++;
        $display("[TB] FAIL overrun_byte%0d: got %h want %h", i, rx4[i], exp_byte(v, i));
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [15:0] v0, v1;
    v0 = 16'hBEEF;
    v1 = 16'h0042;
    rx4.delete();
    se4 = 0;
    bus4.sample_i = v0;
    bus4.sample_valid_i = 1'b1;
    @(negedge clk);
    bus4.sample_i = v1;
    wait_ready4(n);
    checks++;
    if (n !== 60 * FAST || bus4.tx_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got %0d cycles tx=%b want %0d tx=1", n, bus4.tx_o, 60 * FAST);
    end
    @(negedge clk);
    checks++;
    if ({bus4.sample_ready_o, bus4.tx_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL b2b_restart: got ready,tx=%b want 00", {bus4.sample_ready_o, bus4.tx_o});
    end
    bus4.sample_valid_i = 1'b0;
    wait_ready4(n);
    repeat (4) @(negedge clk);
    checks++;
    if (rx4.size() !== 12 || se4 !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d bytes %0d bad stops want 12 0", rx4.size(), se4);
    end
    for (int i = 0; i < 12 && i < rx4.size(); i++) begin
      checks++;
      if (rx4[i] !== exp_byte((i < 6) ? v0 : v1, i % 6)) begin
        errors++;
        $display("[TB] FAIL b2b_byte%0d: got %h want %h", i, rx4[i], exp_byte((i < 6) ? v0 : v1, i % 6));
      end
    end
  endtask

  task automatic test_random_frames;
    int n;
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 16'($urandom);
      rx4.delete();
      se4 = 0;
      send4(v);
      wait_ready4(n);
      repeat (4) @(negedge clk);
      checks++;
      if (rx4.size() !== 6 || se4 !== 0) begin
        errors++;
        $display("[TB] FAIL random_count: sample %h got %0d bytes %0d bad stops want 6 0", v, rx4.size(), se4);
      end
      for (int i = 0; i < 6 && i < rx4.size(); i++) begin
        checks++;
        if (rx4[i] !== exp_byte(v, i)) begin
          errors++;
          $display("[TB] FAIL random_byte%0d: sample %h got %h want %h", i, v, rx4[i], exp_byte(v, i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    int lows;
    logic [15:0] v;
    bus434.sample_i = 16'($urandom);
    bus434.sample_valid_i = 1'b1;
    @(negedge clk);
    bus434.sample_valid_i = 1'b0;
    repeat (25 * SLOW) @(negedge clk);
    checks++;
    if (bus434.busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_busy: got %b want 1", bus434.busy_o);
    end
    rst_slow = 1'b1;
    @(negedge clk);
    rst_slow = 1'b0;
    checks++;
    if ({bus434.tx_o, bus434.sample_ready_o, bus434.busy_o, bus434.overrun_o} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL midreset_state: got %b want 1100",
               {bus434.tx_o, bus434.sample_ready_o, bus434.busy_o, bus434.overrun_o});
    end
    lows = 0;
    repeat (5000) begin
      @(negedge clk);
      if (bus434.tx_o !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_line: got %0d low cycles want 0", lows);
    end
    v = 16'h00C8;
    rx434.delete();
    se434 = 0;
    bus434.sample_i = v;
    bus434.sample_valid_i = 1'b1;
    @(negedge clk);
    bus434.sample_valid_i = 1'b0;
    n = 0;
    while (bus434.sample_ready_o !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 60 * SLOW) begin
      errors++;
      $display("[TB] FAIL midreset_len: got %0d cycles want %0d", n, 60 * SLOW);
    end
    repeat (500) @(negedge clk);
    checks++;
    if (rx434.size() !== 6 || se434 !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d bytes %0d bad stops want 6 0", rx434.size(), se434);
    end
    for (int i = 0; i < 6 && i < rx434.size(); i++) begin
      checks++;
      if (rx434[i] !== exp_byte(v, i)) begin
        errors++;
        $display("[TB] FAIL midreset_byte%0d: got %h want %h", i, rx434[i], exp_byte(v, i));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_slow = 1'b1;
    bus4.sample_i = 16'h0000;
    bus4.sample_valid_i = 1'b0;
    bus434.sample_i = 16'h0000;
    bus434.sample_valid_i = 1'b0;

    test_reset();
    test_single_frame();
    test_digit_extremes();
    test_overrun();
    test_back_to_back();
    test_random_frames();
    test_reset_mid_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
